// File: rtl/regfile_mp.sv
// Multi-ported register file with a per-register pending-write scoreboard.
// Reads and busy flags are combinational; only storage and counters are registered.
module regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned NUM_RD = 4,
    parameter int unsigned CNT_W  = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic [NUM_WR-1:0]          wen,
    input  logic [NUM_WR*ADDR_W-1:0]   waddr,
    input  logic [NUM_WR*DATA_W-1:0]   wdata,
    input  logic [NUM_WR-1:0]          set_en,
    input  logic [NUM_WR*ADDR_W-1:0]   set_addr,
    output logic [NUM_WR-1:0]          set_ok
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;
    localparam int unsigned CNT_MAX  = (2 ** CNT_W) - 1;
    localparam int unsigned SUM_W    = CNT_W + $clog2(NUM_WR + 1) + 1;

    logic [DATA_W-1:0] regs    [NUM_REGS];
    logic [CNT_W-1:0]  cnt     [NUM_REGS];
    logic [CNT_W-1:0]  cnt_nxt [NUM_REGS];
    logic [NUM_WR-1:0] claim_ok;

    logic [SUM_W-1:0]  claim_sum;
    logic [SUM_W-1:0]  upd_sum;
    logic [SUM_W-1:0]  upd_dec;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [SUM_W-1:0]  rd_match;
    logic              rd_busy;

    // Claim acceptance: lower-index ports win when claims would overflow a counter.
    always_comb begin
        claim_ok  = '1;
        claim_sum = '0;
        for (int unsigned j = 0; j < NUM_WR; j++) begin
            if (set_en[j] && (set_addr[j*ADDR_W +: ADDR_W] != '0)) begin
                claim_sum = SUM_W'(cnt[set_addr[j*ADDR_W +: ADDR_W]]);
                for (int unsigned k = 0; k < NUM_WR; k++) begin
                    if ((k <= j) && set_en[k] &&
                        (set_addr[k*ADDR_W +: ADDR_W] == set_addr[j*ADDR_W +: ADDR_W])) begin
                        claim_sum = claim_sum + SUM_W'(1);
                    end
                end
                if (claim_sum > SUM_W'(CNT_MAX)) begin
                    claim_ok[j] = 1'b0;
                end
            end
        end
    end

    assign set_ok = rst ? '1 : claim_ok;

    // Counter update: accepted claims add, writes subtract, floor at zero.
    always_comb begin
        upd_sum = '0;
        upd_dec = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            upd_sum = SUM_W'(cnt[r]);
            upd_dec = '0;
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (set_en[j] && claim_ok[j] && (set_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    upd_sum = upd_sum + SUM_W'(1);
                end
                if (wen[j] && (waddr[j*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    upd_dec = upd_dec + SUM_W'(1);
                end
            end
            if (r == 0) begin
                cnt_nxt[r] = '0;
            end else if (upd_dec > upd_sum) begin
                cnt_nxt[r] = '0;
            end else begin
                cnt_nxt[r] = CNT_W'(upd_sum - upd_dec);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
        end
    end

    // Later ports overwrite earlier ones on address collisions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wen[j] && (waddr[j*ADDR_W +: ADDR_W] != '0)) begin
                    regs[waddr[j*ADDR_W +: ADDR_W]] <= wdata[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Read ports with optional same-cycle forwarding; the forwarded write retires busy.
    always_comb begin
        rdata    = '0;
        rbusy    = '0;
        rd_addr  = '0;
        rd_data  = '0;
        rd_match = '0;
        rd_busy  = 1'b0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_addr  = raddr[i*ADDR_W +: ADDR_W];
            rd_data  = regs[rd_addr];
            rd_match = '0;
            for (int unsigned j = 0; j < NUM_WR; j++) begin
                if (wen[j] && (waddr[j*ADDR_W +: ADDR_W] == rd_addr)) begin
                    rd_match = rd_match + SUM_W'(1);
                    if (BYPASS) begin
                        rd_data = wdata[j*DATA_W +: DATA_W];
                    end
                end
            end
            if (BYPASS) begin
                rd_busy = SUM_W'(cnt[rd_addr]) > rd_match;
            end else begin
                rd_busy = cnt[rd_addr] != '0;
            end
            if (rst || (rd_addr == '0)) begin
                rd_data = '0;
                rd_busy = 1'b0;
            end
            rdata[i*DATA_W +: DATA_W] = rd_data;
            rbusy[i]                  = rd_busy;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one forwarding and one non-forwarding instance
// share stimulus; expected outputs are queued per step and drained before the edge.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NW = 2;
    localparam int NR = 4;

    localparam int RDA = 0;
    localparam int BSA = 1;
    localparam int OKA = 2;
    localparam int RDB = 3;
    localparam int BSB = 4;
    localparam int OKB = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  raddr;
    logic [NW-1:0]     wen;
    logic [NW*AW-1:0]  waddr;
    logic [NW*DW-1:0]  wdata;
    logic [NW-1:0]     set_en;
    logic [NW*AW-1:0]  set_addr;

    logic [NR*DW-1:0]  rdata_a, rdata_b;
    logic [NR-1:0]     rbusy_a, rbusy_b;
    logic [NW-1:0]     set_ok_a, set_ok_b;

    typedef struct {
        string       tag;
        int          kind;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_WR(NW), .NUM_RD(NR), .CNT_W(2), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .set_en(set_en), .set_addr(set_addr), .set_ok(set_ok_a)
    );

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_WR(NW), .NUM_RD(NR), .CNT_W(2), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .set_en(set_en), .set_addr(set_addr), .set_ok(set_ok_b)
    );

    function automatic logic [31:0] observe(input int kind, input int idx);
        case (kind)
            RDA:     return rdata_a[idx*DW +: DW];
            BSA:     return {31'b0, rbusy_a[idx]};
            OKA:     return {30'b0, set_ok_a};
            RDB:     return rdata_b[idx*DW +: DW];
            BSB:     return {31'b0, rbusy_b[idx]};
            default: return {30'b0, set_ok_b};
        endcase
    endfunction

    function automatic void exp(input string tag, input int kind, input int idx, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.idx  = idx;
        e.val  = val;
        sbq.push_back(e);
    endfunction

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = observe(e.kind, e.idx);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle();
        raddr    = '0;
        wen      = '0;
        waddr    = '0;
        wdata    = '0;
        set_en   = '0;
        set_addr = '0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wen[p]             = 1'b1;
        waddr[p*AW +: AW]  = a;
        wdata[p*DW +: DW]  = d;
    endtask

    task automatic clm(input int p, input logic [AW-1:0] a);
        set_en[p]            = 1'b1;
        set_addr[p*AW +: AW] = a;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        raddr[p*AW +: AW] = a;
    endtask

    // Inputs are applied at the falling edge; outputs checked 1ns later, before the rising edge.
    task automatic step();
        #1 drain();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);

        clm(0, 5'd2); rd(0, 5'd2);
        exp("rst_rdata", RDA, 0, 32'h0);
        exp("rst_rbusy", BSA, 0, 32'h0);
        exp("rst_set_ok", OKA, 0, 32'h3);
        exp("rst_set_ok_b", OKB, 0, 32'h3);
        step();
        rst = 1'b0;
        idle(); rd(0, 5'd2);
        exp("rst_claim_ignored", BSB, 0, 32'h0);
        step();

        // r0 hardwired
        idle(); wr(0, 5'd0, 32'hFFFF_FFFF); clm(0, 5'd0); clm(1, 5'd0); rd(0, 5'd0);
        exp("r0_rdata", RDA, 0, 32'h0);
        exp("r0_rbusy", BSA, 0, 32'h0);
        exp("r0_set_ok", OKA, 0, 32'h3);
        step();
        idle(); rd(0, 5'd0);
        exp("r0_after", RDB, 0, 32'h0);
        exp("r0_busy_after", BSB, 0, 32'h0);
        step();

        // write collision on r7
        idle(); wr(0, 5'd7, 32'h5555_5555);
        step();
        idle(); wr(0, 5'd7, 32'h1111_1111); wr(1, 5'd7, 32'h2222_2222); rd(0, 5'd7); rd(1, 5'd7);
        exp("coll_fwd_p0", RDA, 0, 32'h2222_2222);
        exp("coll_fwd_p1", RDA, 1, 32'h2222_2222);
        exp("coll_nofwd", RDB, 0, 32'h5555_5555);
        step();
        idle(); rd(0, 5'd7);
        exp("coll_stored_a", RDA, 0, 32'h2222_2222);
        exp("coll_stored_b", RDB, 0, 32'h2222_2222);
        step();

        // non-colliding dual write
        idle(); wr(0, 5'd8, 32'h8888_0008); wr(1, 5'd10, 32'hAAAA_000A);
        step();
        idle(); rd(2, 5'd8); rd(3, 5'd10);
        exp("dual_wr_r8", RDB, 2, 32'h8888_0008);
        exp("dual_wr_r10", RDB, 3, 32'hAAAA_000A);
        step();

        // scoreboard on r3
        idle(); clm(0, 5'd3); rd(0, 5'd3);
        exp("sb_claim_no_busy_a", BSA, 0, 32'h0);
        exp("sb_claim_no_busy_b", BSB, 0, 32'h0);
        exp("sb_claim1_ok", OKA, 0, 32'h3);
        step();
        idle(); clm(1, 5'd3);
        exp("sb_claim2_ok", OKA, 0, 32'h3);
        step();
        idle(); rd(0, 5'd3);
        exp("sb_cnt2_busy_a", BSA, 0, 32'h1);
        exp("sb_cnt2_busy_b", BSB, 0, 32'h1);
        step();
        idle(); wr(0, 5'd3, 32'h3333_0001); rd(0, 5'd3);
        exp("sb_wr1_busy_a", BSA, 0, 32'h1);
        exp("sb_wr1_fwd", RDA, 0, 32'h3333_0001);
        exp("sb_wr1_nofwd", RDB, 0, 32'h0);
        step();
        idle(); rd(0, 5'd3);
        exp("sb_cnt1_busy_a", BSA, 0, 32'h1);
        exp("sb_cnt1_busy_b", BSB, 0, 32'h1);
        step();
        idle(); wr(1, 5'd3, 32'h3333_0002); rd(0, 5'd3);
        exp("sb_wr2_busy_a", BSA, 0, 32'h0);
        exp("sb_wr2_fwd", RDA, 0, 32'h3333_0002);
        exp("sb_wr2_busy_b", BSB, 0, 32'h1);
        exp("sb_wr2_nofwd", RDB, 0, 32'h3333_0001);
        step();
        idle(); rd(0, 5'd3);
        exp("sb_cnt0_busy_a", BSA, 0, 32'h0);
        exp("sb_cnt0_busy_b", BSB, 0, 32'h0);
        exp("sb_cnt0_data", RDB, 0, 32'h3333_0002);
        step();

        // spurious write clamps at zero
        idle(); wr(0, 5'd11, 32'h0000_000B);
        step();
        idle(); clm(0, 5'd11);
        step();
        idle(); rd(1, 5'd11);
        exp("clamp_busy", BSB, 1, 32'h1);
        step();

        // saturation on r9
        for (int n = 0; n < 3; n++) begin
            idle(); clm(0, 5'd9);
            exp("sat_fill_ok", OKA, 0, 32'h3);
            step();
        end
        idle(); clm(0, 5'd9); rd(0, 5'd9);
        exp("sat_reject", OKA, 0, 32'h2);
        exp("sat_busy_b", BSB, 0, 32'h1);
        step();
        idle(); clm(0, 5'd9); wr(1, 5'd9, 32'h0000_0099); rd(0, 5'd9);
        exp("sat_reject_with_wr", OKA, 0, 32'h2);
        exp("sat_wr_busy_a", BSA, 0, 32'h1);
        exp("sat_wr_fwd", RDA, 0, 32'h0000_0099);
        step();
        idle(); clm(0, 5'd9); clm(1, 5'd9);
        exp("sat_cnt2_dual_a", OKA, 0, 32'h1);
        exp("sat_cnt2_dual_b", OKB, 0, 32'h1);
        step();
        idle(); clm(0, 5'd9);
        exp("sat_cnt3_again", OKA, 0, 32'h2);
        step();

        // dual claim on r4 with cnt = 2
        for (int n = 0; n < 2; n++) begin
            idle(); clm(0, 5'd4);
            step();
        end
        idle(); clm(0, 5'd4); clm(1, 5'd4);
        exp("dual_claim_ok", OKA, 0, 32'h1);
        step();
        idle(); clm(1, 5'd4);
        exp("dual_claim_cnt3", OKA, 0, 32'h1);
        step();

        // asynchronous reset mid-run
        idle(); wr(0, 5'd5, 32'hDEAD_BEEF);
        step();
        idle(); clm(0, 5'd5);
        step();
        idle(); rd(0, 5'd5);
        exp("pre_rst_data", RDA, 0, 32'hDEAD_BEEF);
        exp("pre_rst_busy", BSA, 0, 32'h1);
        #1 drain();
        @(posedge clk);
        #2 rst = 1'b1;
        clm(0, 5'd5);
        #1;
        exp("async_rst_data", RDA, 0, 32'h0);
        exp("async_rst_busy", BSA, 0, 32'h0);
        exp("async_rst_data_b", RDB, 0, 32'h0);
        exp("async_rst_set_ok", OKA, 0, 32'h3);
        drain();
        @(negedge clk);
        rst = 1'b0;
        idle(); rd(0, 5'd5); rd(1, 5'd7);
        exp("post_rst_r5", RDA, 0, 32'h0);
        exp("post_rst_busy", BSA, 0, 32'h0);
        exp("post_rst_r7", RDA, 1, 32'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Multi-ported general register file with a per-register pending-write scoreboard, for the next-generation multi-issue core.
- Generalises the dual-issue register file to parametrised data width, register count, write-port count and read-port count.
- Adds a pending-write scoreboard so issue logic can detect RAW hazards on registers not yet written back.
- Sits between decode/issue (reads, destination claims) and writeback (writes).

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width; file holds 2**ADDR_W registers
NUM_WR, 2, write ports; higher index has higher priority
NUM_RD, 4, read ports
CNT_W, 2, width of per-register pending-write counter
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
raddr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
rbusy  out  NUM_RD  read register still has outstanding writes
wen  in  NUM_WR  write enable per port
waddr  in  NUM_WR*ADDR_W  write addresses
wdata  in  NUM_WR*DATA_W  write data
set_en  in  NUM_WR  issue claims a destination (pending count +1)
set_addr  in  NUM_WR*ADDR_W  claimed destination addresses
set_ok  out  NUM_WR  claim accepted: target count plus same-cycle claims stays at or below max

Behaviour:
- Reset: asynchronous on rst rising; all registers = 0 and all counters = 0 immediately. While rst is high:
  - writes and claims are ignored;
  - rdata = 0, rbusy = 0, set_ok = all 1.
- Register 0: hardwired zero.
  - Writes to it are ignored.
  - Reads return 0 with rbusy = 0.
  - Claims of it are ignored, and set_ok = 1 for those claims.
- Write: on posedge clk, each wen[j] with waddr[j] != 0 updates that register.
  - If several ports target the same address, the highest index j wins.
  - Non-colliding ports all commit in the same cycle.
- Read (combinational, zero latency):
  - raddr = 0 -> 0.
  - Else, if BYPASS = 1 and any enabled write port matches -> wdata of the highest-index matching port.
  - Else -> stored value.
  - Each read port uses only its own raddr.
- Scoreboard counter per register, updated at posedge clk:
  - next = cnt + (number of set_en ports matching) - (number of wen ports matching), including duplicate addresses.
  - A simultaneous set and write to the same register nets to unchanged.
  - A decrement below 0 clamps at 0 (spurious write, no fault).
  - A claim with set_ok = 0 is ignored entirely (no increment for that port); issue must stall.
  - set_ok[j] = 0 when cnt[set_addr[j]] + (claims by ports 0..j to that address) > 2**CNT_W - 1, so the lower ports get priority among over-limit claims.
- rbusy[i]:
  - BYPASS = 1: (cnt[raddr[i]] > this-cycle matching wen count). The final in-flight write being forwarded reads as not busy.
  - BYPASS = 0: cnt != 0.
  - Same-cycle claims do not affect rbusy.
- No pipeline registers on read paths; storage plus counters only.

Test Plan:
- Reset mid-run: write 0xDEADBEEF to r5, claim r5, then assert rst asynchronously between edges -> rdata for r5 = 0 and rbusy = 0 before the next edge; after release, r5 reads 0.
- Write collision: wen = 2'b11, waddr = {7,7}, wdata = {0x2222_2222 (port1), 0x1111_1111 (port0)} -> same-cycle read of r7 = 0x22222222 (BYPASS = 1); after the edge r7 = 0x22222222. With BYPASS = 0, the same-cycle read returns the old value.
- r0 rules: write 0xFFFF_FFFF to r0 and claim r0 -> reads 0, rbusy = 0, set_ok = 1, counter stays 0.
- Scoreboard: claim r3 on two consecutive cycles -> cnt = 2, rbusy = 1.
  - One write to r3 -> after the edge cnt = 1, still busy.
  - Second write cycle -> rbusy = 0 in that same cycle (BYPASS = 1); after the edge cnt = 0.
- Saturation (CNT_W = 2): claim r9 three times -> cnt = 3.
  - A fourth claim with no write -> set_ok[0] = 0 and cnt stays 3.
  - The same claim together with a write to r9 -> still set_ok = 0 (rule uses current cnt); next cycle cnt = 2.
- Dual claim: set_en = 2'b11, both ports to r4, with cnt[r4] = 2 -> set_ok = 2'b01 and cnt becomes 3.
